// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low hex glyphs
// (a..g on bits 6..0), blank glyph, one-hot anode codes and the digit order.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  // The board glyph for 7 lights the f segment as well as a, b and c.
  localparam logic [6:0] SEG_7 = 7'b0001101;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN0 = 4'b0001;
  localparam logic [3:0] AN1 = 4'b0010;
  localparam logic [3:0] AN2 = 4'b0100;
  localparam logic [3:0] AN3 = 4'b1000;

  // Digit slot order, rightmost first.
  typedef enum logic [1:0] {
    DIG_RES = 2'd0,
    DIG_B   = 2'd1,
    DIG_A   = 2'd2,
    DIG_F   = 2'd3
  } digit_e;

endpackage

// File: rtl/seg_scan_if.sv
// Bundle between the ALU stage / board and the scanner: capture inputs,
// blank control and the multiplexed display drive.
interface seg_scan_if;
  import seg_pkg::*;

  logic       ld;
  logic [3:0] res;
  logic [3:0] f;
  logic [3:0] a;
  logic [3:0] b;
  logic       d0;
  logic       d1;
  logic       blank;
  logic [6:0] du;
  logic       dp;
  logic [3:0] bank;

  modport master (
    output ld, res, f, a, b, d0, d1, blank,
    input  du, dp, bank
  );

  modport slave (
    input  ld, res, f, a, b, d0, d1, blank,
    output du, dp, bank
  );

endinterface

// File: rtl/seg_scan_hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed display scanner: captures ALU result/opcode/operands
// on ld and refreshes them through one segment bus with a blinking result digit.
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter int BLINK_SCANS = 64
) (
  input logic      clk,
  input logic      rst,
  seg_scan_if.slave bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_SCANS - 1);

  logic [CW-1:0] cnt;
  digit_e        idx;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          tick;

  logic [3:0] l_res, l_f, l_a, l_b;
  logic       l_d0, l_d1;

  logic [3:0] nib;
  logic [6:0] seg;
  logic [6:0] du_d;
  logic       dp_d;
  logic [3:0] bank_d;

  assign tick = (cnt == CNT_MAX);

  // NOTE: every register below uses <= so all state updates on one edge see
  // the pre-edge values; a blocking = here would chain updates within a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= DIG_RES;
      bcnt  <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= digit_e'(idx + 2'd1);
        if (idx == DIG_F) begin
          if (bcnt == BCNT_MAX) begin
            bcnt  <= '0;
            phase <= ~phase;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the capture latches are a handful of flops, not a memory, and the
  // display must read 0000 after reset, so they are cleared with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_res <= '0;
      l_f   <= '0;
      l_a   <= '0;
      l_b   <= '0;
      l_d0  <= 1'b0;
      l_d1  <= 1'b0;
    end else if (bus.ld) begin
      l_res <= bus.res;
      l_f   <= bus.f;
      l_a   <= bus.a;
      l_b   <= bus.b;
      l_d0  <= bus.d0;
      l_d1  <= bus.d1;
    end
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    nib = l_res;
    unique case (idx)
      DIG_B:   nib = l_b;
      DIG_A:   nib = l_a;
      DIG_F:   nib = l_f;
      default: nib = l_res;
    endcase
  end

  hex7seg u_hex (
    .nib (nib),
    .seg (seg)
  );

  always_comb begin
    du_d   = seg;
    dp_d   = 1'b1;
    bank_d = AN0;
    unique case (idx)
      DIG_RES: begin
        bank_d = AN0;
        dp_d   = ~l_d1;
        // Flagged result blinks off during the second phase; anode stays on.
        if (l_d1 && phase) begin
          du_d = SEG_BLANK;
          dp_d = 1'b1;
        end
      end
      DIG_B:   bank_d = AN1;
      DIG_A:   bank_d = AN2;
      default: begin
        bank_d = AN3;
        dp_d   = ~l_d0;
      end
    endcase
    if (bus.blank) bank_d = 4'b0000;
  end

  // Segments and anode register on the same edge so digits never ghost.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.du   <= SEG_0;
      bus.dp   <= 1'b1;
      bus.bank <= AN0;
    end else begin
      bus.du   <= du_d;
      bus.dp   <= dp_d;
      bus.bank <= bank_d;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with CLK_DIV=4, BLINK_SCANS=2: load vector table
// plus hand-written reset, blink, simultaneous-load, blank and reset sequences.
module tb_seg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  seg_scan_if bus ();

  seg_scan #(.CLK_DIV(4), .BLINK_SCANS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      res, f, a, b;
    logic            d0;
    logic [3:0][6:0] du;    // {idx3, idx2, idx1, idx0}
    logic            dp3;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns at the first negedge (possibly the current one) showing target.
  task automatic wait_bank(input logic [3:0] target);
    int n = 0;
    while (bus.bank !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.bank !== target) check("bank_timeout", 32'(bus.bank), 32'(target));
  endtask

  task automatic load(input logic [3:0] r, fv, av, bv, input logic d0v, d1v);
    bus.ld = 1'b1; bus.res = r; bus.f = fv; bus.a = av; bus.b = bv;
    bus.d0 = d0v; bus.d1 = d1v;
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  logic [3:0] onehot [4];
  logic [6:0] blink_v [8];
  int         len;

  initial begin
    onehot[0] = 4'b0001; onehot[1] = 4'b0010; onehot[2] = 4'b0100; onehot[3] = 4'b1000;
    vecs[0] = '{4'hA, 4'h2, 4'h7, 4'h3, 1'b0,
                {7'b0010010, 7'b0001101, 7'b0000110, 7'b0001000}, 1'b1};
    vecs[1] = '{4'h0, 4'h8, 4'h4, 4'h1, 1'b1,
                {7'b0000000, 7'b1001100, 7'b1001111, 7'b0000001}, 1'b0};
    vecs[2] = '{4'hC, 4'hF, 4'hE, 4'hD, 1'b0,
                {7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001}, 1'b1};
    vecs[3] = '{4'hB, 4'h3, 4'hD, 4'h2, 1'b1,
                {7'b0000110, 7'b1000010, 7'b0010010, 7'b1100000}, 1'b0};

    bus.ld = 0; bus.res = 0; bus.f = 0; bus.a = 0; bus.b = 0;
    bus.d0 = 0; bus.d1 = 0; bus.blank = 0;

    // Reset state and the three following zero digits, 4 cycles each.
    repeat (2) @(negedge clk);
    check("rst_bank", 32'(bus.bank), 32'(4'b0001));
    check("rst_du",   32'(bus.du),   32'(7'b0000001));
    check("rst_dp",   32'(bus.dp),   32'(1'b1));
    rst = 1'b0;
    for (int k = 1; k < 4; k++) begin
      wait_bank(onehot[k]);
      check("rst_slot_du", 32'(bus.du), 32'(7'b0000001));
      len = 1;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.bank !== onehot[k]) break;
        len++;
      end
      check("slot_len", 32'(len), 32'd4);
    end

    // Table of loads, each checked over one full scan.
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].res, vecs[v].f, vecs[v].a, vecs[v].b, vecs[v].d0, 1'b0);
      wait_bank(4'b1000);
      for (int d = 0; d < 4; d++) begin
        wait_bank(onehot[d]);
        @(negedge clk);
        check("vec_du", 32'(bus.du), 32'(vecs[v].du[d]));
        check("vec_dp", 32'(bus.dp), (d == 3) ? 32'(vecs[v].dp3) : 32'd1);
      end
    end

    // ld held for three cycles: the last value wins.
    bus.ld = 1'b1; bus.d0 = 0; bus.d1 = 0;
    bus.res = 4'h1; @(negedge clk);
    bus.res = 4'h2; @(negedge clk);
    bus.res = 4'h3; @(negedge clk);
    bus.ld = 1'b0;
    wait_bank(4'b1000);
    wait_bank(4'b0001);
    @(negedge clk);
    check("hold_ld_du", 32'(bus.du), 32'(7'b0000110));

    // Flags: result 5 with both flags; result digit blinks every 2 scans.
    load(4'h5, 4'h1, 4'h2, 4'h3, 1'b1, 1'b1);
    for (int s = 0; s < 8; s++) begin
      wait_bank(4'b0001);
      @(negedge clk);
      blink_v[s] = bus.du;
      if (bus.du === 7'b1111111) begin
        check("blink_off_dp", 32'(bus.dp), 32'd1);
      end else begin
        check("blink_on_du", 32'(bus.du), 32'(7'b0100100));
        check("blink_on_dp", 32'(bus.dp), 32'd0);
      end
      wait_bank(4'b0010);
      check("flag_dp1", 32'(bus.dp), 32'd1);
      wait_bank(4'b1000);
      check("flag_dp3", 32'(bus.dp), 32'd0);
    end
    for (int s = 0; s < 6; s++)
      check("blink_alt", 32'(blink_v[s] !== blink_v[s+2]), 32'd1);

    // ld together with the tick that wraps idx 3 -> 0.
    wait_bank(4'b0100);
    wait_bank(4'b1000);
    repeat (2) @(negedge clk);
    bus.ld = 1'b1; bus.res = 4'hF; bus.f = 4'h4; bus.a = 4'h5; bus.b = 4'h1;
    bus.d0 = 1'b1; bus.d1 = 1'b0;
    @(negedge clk);
    bus.ld = 1'b0;
    check("simul_bank3", 32'(bus.bank), 32'(4'b1000));
    @(negedge clk);
    check("simul_bank0", 32'(bus.bank), 32'(4'b0001));
    check("simul_du",    32'(bus.du),   32'(7'b0111000));

    // Blank for 10 cycles starting at the second cycle of the idx-0 slot.
    wait_bank(4'b1000);
    wait_bank(4'b0001);
    bus.blank = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("blank_bank", 32'(bus.bank), 32'd0);
    end
    bus.blank = 1'b0;
    @(negedge clk);
    check("unblank_a", 32'(bus.bank), 32'(4'b0100));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("unblank_f", 32'(bus.bank), 32'(4'b1000));
    end
    @(negedge clk);
    check("unblank_res", 32'(bus.bank), 32'(4'b0001));

    // Reset in the middle of a slot clears state and latches.
    wait_bank(4'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_bank", 32'(bus.bank), 32'(4'b0001));
    check("mid_rst_du",   32'(bus.du),   32'(7'b0000001));
    check("mid_rst_dp",   32'(bus.dp),   32'd1);
    rst = 1'b0;
    wait_bank(4'b0100);
    check("clr_a_du", 32'(bus.du), 32'(7'b0000001));
    wait_bank(4'b1000);
    check("clr_f_du", 32'(bus.du), 32'(7'b0000001));
    check("clr_f_dp", 32'(bus.dp), 32'd1);
    wait_bank(4'b0001);
    check("clr_res_du", 32'(bus.du), 32'(7'b0000001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
